// File: rtl/main_mem_responder.sv
// Main-memory end of the cache controller's main_mem_* handshake: fixed-latency
// 512-bit block reads and 32-bit word writes over self-initialising on-chip storage.
module main_mem_responder #(
  parameter int DEPTH       = 1024,
  parameter int LATENCY     = 3,
  parameter int INIT_EN     = 1,
  parameter int OFFSET_BITS = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  main_mem_addr,
  input  logic [31:0]  main_mem_data_out,
  input  logic         main_mem_read_req,
  input  logic         main_mem_write_req,
  output logic [511:0] main_mem_data_in,
  output logic         main_mem_ready,
  output logic         mem_busy,
  output logic         mem_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WW = OFFSET_BITS - 2;

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  logic [511:0]  storage [DEPTH];
  logic [1:0]    state;
  logic [7:0]    count;
  logic [AW-1:0] init_idx;
  logic [AW-1:0] blk;
  logic [WW-1:0] word;
  logic [31:0]   wdata;
  logic          op_write;
  logic          oor;

  logic [31:0]   req_blk;
  logic          req_oor;
  logic          init_we;
  logic          word_we;
  logic          unused_ok;

  assign req_blk   = 32'(main_mem_addr >> OFFSET_BITS);
  assign req_oor   = req_blk >= 32'(DEPTH);
  assign unused_ok = ^main_mem_addr[1:0];

  // Storage has no reset; gating with rst keeps an aborted write from landing.
  assign init_we = (state == ST_INIT) && !rst;
  assign word_we = (state == ST_WAIT) && (count == 8'd0) && op_write && !oor && !rst;

  always_ff @(posedge clk) begin
    if (init_we)
      storage[init_idx] <= 512'(init_idx);
    else if (word_we)
      storage[blk][{word, 5'b0} +: 32] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= (INIT_EN != 0) ? ST_INIT : ST_IDLE;
      mem_busy         <= (INIT_EN != 0);
      main_mem_ready   <= 1'b0;
      main_mem_data_in <= '0;
      mem_err          <= 1'b0;
      count            <= 8'd0;
      init_idx         <= '0;
      blk              <= '0;
      word             <= '0;
      wdata            <= '0;
      op_write         <= 1'b0;
      oor              <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          init_idx <= init_idx + 1'b1;
          if (init_idx == AW'(DEPTH - 1)) begin
            state    <= ST_IDLE;
            mem_busy <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (main_mem_write_req || main_mem_read_req) begin
            op_write <= main_mem_write_req;
            blk      <= req_blk[AW-1:0];
            word     <= main_mem_addr[OFFSET_BITS-1:2];
            wdata    <= main_mem_data_out;
            oor      <= req_oor;
            if (req_oor)
              mem_err <= 1'b1;
            count    <= 8'(LATENCY);
            mem_busy <= 1'b1;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (count != 8'd0) begin
            count <= count - 8'd1;
          end else begin
            if (!op_write)
              main_mem_data_in <= oor ? '0 : storage[blk];
            main_mem_ready <= 1'b1;
            state          <= ST_RESP;
          end
        end
        ST_RESP: begin
          main_mem_ready <= 1'b0;
          mem_busy       <= 1'b0;
          state          <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/main_mem_responder.md
Name: main_mem_responder

Overview:
- Synthesizable main-memory responder for the cache controller's block-fill / write-through interface.
- It is the memory end of the main_mem_* handshake: accepts level-held read/write requests, waits a fixed latency, then performs a 512-bit block read or a 32-bit word write, and pulses ready for one cycle.
- Holds DEPTH blocks of on-chip storage.
- After reset it self-initialises every block to its own index.

Parameters:
- DEPTH, 1024, number of 512-bit blocks (power of two).
- LATENCY, 3, wait cycles between request acceptance and the completion edge (0 to 255).
- INIT_EN, 1, when 1 the storage is walked after reset, writing block i = i zero-extended to 512 bits.
- OFFSET_BITS, 6, byte-offset bits per block (64-byte blocks).

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- main_mem_addr  in  32  byte address; block = addr>>OFFSET_BITS, word = addr[5:2].
- main_mem_data_out  in  32  write data from the cache controller.
- main_mem_read_req  in  1  level read request, held until ready is seen.
- main_mem_write_req  in  1  level write request, held until ready is seen.
- main_mem_data_in  out  512  read block to the cache controller.
- main_mem_ready  out  1  one-cycle completion pulse.
- mem_busy  out  1  high in INIT, WAIT and RESP.
- mem_err  out  1  sticky; set by any out-of-range access.

Behaviour:
- Reset (asynchronous): ready=0, data_in=0, err=0, counter=0, latched request cleared. State = INIT if INIT_EN, else IDLE. busy = INIT_EN.
- Storage contents are not reset. They are defined only after INIT completes.

State INIT:
- Writes block k = k on each cycle, k = 0..DEPTH-1.
- Requests are ignored.
- After k=DEPTH-1 is written: state → IDLE, busy → 0. Total duration is DEPTH cycles.

State IDLE:
- Samples requests on each edge.
- Write has priority when both read and write are high.
- On acceptance, latch: op, block index, word index, write data. Load counter = LATENCY, set busy=1, state → WAIT.
- Address and data inputs are don't-care after the acceptance edge.

State WAIT:
- If counter != 0, decrement.
- If counter == 0, this is the completion edge:
  - read: data_in ← storage[block];
  - write: storage[block][word*32 +: 32] ← latched data. data_in is unchanged.
- On the completion edge: ready ← 1, state → RESP.
- Timing: acceptance at edge E, completion at edge E+LATENCY+1, ready high for exactly the cycle after that edge. LATENCY=0 gives completion at E+1.

State RESP:
- ready=1 for exactly this one cycle. Requests are ignored, so a request still held this cycle is not re-accepted.
- Next edge: ready ← 0, busy ← 0, state → IDLE.
- A new request can therefore be accepted no earlier than 2 edges after the completion edge.

Out-of-range and ordering rules:
- A block index ≥ DEPTH sets err on the acceptance edge, and the handshake still completes with normal timing.
- Out-of-range read returns all zeros. Out-of-range write is discarded with no storage change.
- A read at completion returns storage as of that edge, including any earlier completed writes; accesses are strictly sequential.
- data_in holds the last read block until the next read completes.

Reset mid-operation:
- Aborts any transaction immediately: ready=0, no pending write is committed, state → INIT/IDLE per INIT_EN.
- Storage written before the reset is retained unless INIT rewrites it.

Test Plan:
1. INIT_EN=1, release rst → busy high for exactly 1024 cycles. Then read addr 0x1000 → data_in = 512'd64, ready high 4 edges after acceptance (LATENCY=3).
2. Write 0x0000_2008 data 0xCAFEBABE, then read 0x2000 → block 128 word 2 = 0xCAFEBABE, word 0 = 0x80, all other words 0. data_in is unchanged by the write.
3. Read and write requests asserted together on the same edge at addr 0x40 → write is performed. Ready pulses once. Requests held through RESP are re-accepted only at RESP+1.
4. Read addr 0x0001_0000 (block 1024, out of range) → err=1 and stays set, data_in = 0, ready at normal latency. A following in-range read still succeeds with err remaining 1.
5. Assert rst during WAIT of a write to 0x3000 (INIT_EN=0 build) → ready never pulses. A subsequent read of 0x3000 returns the pre-write contents.
6. LATENCY=0 build: read 0x40 → completion one edge after acceptance, data_in = 512'd1, single-cycle ready.
